// File: rtl/or_logic_pipe.sv
// or_logic_pipe
//
// Registered multi-lane bitwise logic stage. NIN operand lanes of WIDTH bits
// are combined with a selectable function (OR / NOR / AND / XOR), optionally
// OR-accumulated into a sticky accumulator, and the result is queued in a
// 2-entry output FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          operand beat present
//   in_ready   out  1          stage can accept a beat this cycle
//   in_lanes   in   NIN*WIDTH  lane i = in_lanes[i*WIDTH +: WIDTH]
//   op         in   2          00 OR, 01 NOR, 10 AND, 11 XOR
//   acc_en     in   1          beat is OR-combined with the accumulator
//   acc_clr    in   1          clear accumulator (sideband)
//   out_valid  out  1          result available at FIFO head
//   out_ready  in   1          consumer takes the head this cycle
//   out_data   out  WIDTH      FIFO head (0 when empty)
//   out_any    out  1          reduction OR of out_data

module or_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int NIN   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NIN*WIDTH-1:0]  in_lanes,
    input  logic [1:0]            op,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_any
);

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_NOR = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // FIFO state
    logic [WIDTH-1:0] r_mem [2];
    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;

    // accumulator
    logic [WIDTH-1:0] r_acc;

    // combinational datapath
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_push;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Lane reduction
    // ------------------------------------------------------------------
    always_comb begin
        w_or  = '0;
        w_and = '1;
        w_xor = '0;
        for (int i = 0; i < NIN; i++) begin
            w_or  = w_or  | in_lanes[i*WIDTH +: WIDTH];
            w_and = w_and & in_lanes[i*WIDTH +: WIDTH];
            w_xor = w_xor ^ in_lanes[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_f = w_or;
        unique case (op)
            OP_OR:   w_f = w_or;
            OP_NOR:  w_f = ~w_or;
            OP_AND:  w_f = w_and;
            OP_XOR:  w_f = w_xor;
            default: w_f = w_or;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // Holding in_ready low while rst_n is low keeps upstream from seeing a
    // ready stage during reset, even though the count is already zero.
    assign in_ready  = (r_count != 2'd2) && rst_n;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Accumulate
    // ------------------------------------------------------------------
    // The clear takes effect before a same-cycle accumulate, so a beat with
    // acc_clr and acc_en both set starts a fresh accumulation from f.
    always_comb begin
        w_acc_base = acc_clr ? '0 : r_acc;
        w_result   = w_f;
        w_acc_next = w_acc_base;
        if (w_push && acc_en) begin
            w_result   = w_acc_base | w_f;
            w_acc_next = w_acc_base | w_f;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_result;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_data = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_any  = |out_data;

endmodule
